aes_inv_key_expansion: RTL and testbench

Reverse (decryption-direction) AES-128 key schedule generator for the iterative AES-128 datapath. It is loaded once with the round-10 key and streams round keys K10, K9, … K0, one per accepted output handshake. The inverse cipher round loop consumes these keys directly, so no 11-entry key RAM is needed. It is the counterpart of the forward key_expansion block.

---
 rtl/aes_inv_key_expansion_pkg.sv | 53 +++++
 rtl/aes_inv_key_expansion_if.sv | 24 ++
 rtl/aes_inv_key_expansion_sub_word.sv | 12 +
 rtl/aes_inv_key_expansion.sv | 115 +++++++++++
 tb/tb_aes_inv_key_expansion.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_inv_key_expansion_pkg.sv
// Shared AES-128 key-schedule definitions: round count, FSM states, S-box and Rcon lookups.
package aes_inv_key_expansion_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Forward AES S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_inv_key_expansion_if.sv
// Load/stream handshake between the key schedule and the inverse cipher round loop.
interface aes_inv_key_expansion_if;

    logic         start;
    logic [127:0] key_in;
    logic         abort;
    logic         out_ready;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in, abort, out_ready,
        input  key_valid, key_out, round_idx, busy, done
    );

    modport slave (
        input  start, key_in, abort, out_ready,
        output key_valid, key_out, round_idx, busy, done
    );

endinterface

// File: rtl/aes_inv_key_expansion_sub_word.sv
// 32-bit SubWord: four parallel S-box lookups, shared with the forward key schedule.
module aes_sub_word
    import aes_inv_key_expansion_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_inv_key_expansion.sv
// Reverse AES-128 key schedule: loaded with K10, streams K10..K0 one key per accepted handshake.
module aes_inv_key_expansion
    import aes_inv_key_expansion_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    aes_inv_key_expansion_if.slave   bus
);

    state_e       r_state;
    state_e       w_next_state;
    logic         r_key_valid;
    logic         r_busy;
    logic         r_done;
    logic [127:0] r_key_out;
    logic [3:0]   r_round_idx;

    logic         w_xfer;
    logic         w_load;
    logic         w_advance;
    logic         w_done_d;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_v0, w_v1, w_v2, w_v3;
    logic [31:0]  w_sub;
    logic [127:0] w_prev_key;

    assign w_xfer = r_key_valid && bus.out_ready;

    // Undo one forward expansion step: K(i) -> K(i-1).
    assign {w_w0, w_w1, w_w2, w_w3} = r_key_out;
    assign w_v3 = w_w3 ^ w_w2;
    assign w_v2 = w_w2 ^ w_w1;
    assign w_v1 = w_w1 ^ w_w0;

    aes_sub_word u_sub_word (
        .i_word ({w_v3[23:0], w_v3[31:24]}),
        .o_word (w_sub)
    );

    assign w_v0       = w_w0 ^ w_sub ^ {rcon(r_round_idx), 24'h000000};
    assign w_prev_key = {w_v0, w_v1, w_v2, w_v3};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides both start and a pending transfer.
    always_comb begin
        w_next_state = r_state;
        if (bus.abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next_state = bus.start ? RUN : IDLE;
                RUN:     w_next_state = (w_xfer && (r_round_idx == 4'd0)) ? IDLE : RUN;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Per-state datapath controls.
    always_comb begin
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_done_d  = 1'b0;
        if (bus.abort) begin
            w_load    = 1'b0;
            w_advance = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            case (r_state)
                IDLE: w_load = bus.start;
                RUN: begin
                    w_advance = w_xfer && (r_round_idx != 4'd0);
                    w_done_d  = w_xfer && (r_round_idx == 4'd0);
                end
                default: w_load = 1'b0;
            endcase
        end
    end

    // Registered outputs and key/round registers; key register is untouched on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_key_out   <= 128'h0;
            r_round_idx <= 4'd0;
        end else begin
            r_key_valid <= (w_next_state == RUN);
            r_busy      <= (w_next_state == RUN);
            r_done      <= w_done_d;
            if (w_load) begin
                r_key_out   <= bus.key_in;
                r_round_idx <= 4'(NR);
            end else if (w_advance) begin
                r_key_out   <= w_prev_key;
                r_round_idx <= r_round_idx - 4'd1;
            end
        end
    end

    assign bus.key_valid = r_key_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.key_out   = r_key_out;
    assign bus.round_idx = r_round_idx;

endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Scoreboard bench: expected streams come from an independent forward key expansion.
module tb_aes_inv_key_expansion;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
    } exp_t;

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] FIPS_K0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
    localparam logic [127:0] ZERO_K0  = 128'h0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_inv_key_expansion_if kx ();

    aes_inv_key_expansion dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kx)
    );

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_xfer   = 0;
    logic         hold_pend = 1'b0;
    logic [127:0] hold_key;
    logic [3:0]   hold_idx;

    // Model: GF(2^8) arithmetic and S-box derived from the field inverse.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        if (a == 8'h00) inv = 8'h00;
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Forward-expand from K0 and queue K10..K0 in stream order.
    task automatic push_stream(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        exp_t        e;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0]), m_sbox(t[31:24])}
                    ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 10; r >= 0; r--) begin
            e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            e.idx = 4'(r);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on each transfer and checks hold during stalls.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                n_checks++;
                if (kx.key_out !== hold_key || kx.round_idx !== hold_idx) begin
                    n_fail++;
                    $display("FAIL stall_hold: got idx=%0d key=%h, want idx=%0d key=%h",
                             kx.round_idx, kx.key_out, hold_idx, hold_key);
                end
            end
            if (kx.key_valid === 1'b1 && kx.out_ready === 1'b1 && kx.abort !== 1'b1) begin
                n_xfer++;
                hold_pend = 1'b0;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL xfer_unexpected: got idx=%0d key=%h, want no transfer",
                             kx.round_idx, kx.key_out);
                end else begin
                    e = sb_q.pop_front();
                    if (kx.key_out !== e.key || kx.round_idx !== e.idx) begin
                        n_fail++;
                        $display("FAIL xfer_key: got idx=%0d key=%h, want idx=%0d key=%h",
                                 kx.round_idx, kx.key_out, e.idx, e.key);
                    end
                end
            end else begin
                hold_pend = (kx.key_valid === 1'b1) && (kx.abort !== 1'b1);
                hold_key  = kx.key_out;
                hold_idx  = kx.round_idx;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [127:0] k10, input logic [127:0] k0);
        push_stream(k0);
        kx.key_in = k10;
        kx.start  = 1'b1;
        tick();
        kx.start  = 1'b0;
        kx.key_in = ~k10;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        kx.start = 1'b0; kx.abort = 1'b0; kx.out_ready = 1'b0; kx.key_in = 128'h0;
        #7;
        n_checks++;
        if (kx.key_valid !== 1'b0 || kx.busy !== 1'b0 || kx.done !== 1'b0 ||
            kx.key_out !== 128'h0 || kx.round_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b busy=%b done=%b idx=%0d key=%h, want all 0",
                     kx.key_valid, kx.busy, kx.done, kx.round_idx, kx.key_out);
        end
        #20;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (kx.key_valid !== 1'b0 || kx.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got valid=%b busy=%b, want 0 0", kx.key_valid, kx.busy);
        end
    endtask

    task automatic test_fips_stream();
        int cyc;
        int x0 = n_xfer;
        kx.out_ready = 1'b1;
        begin_run(FIPS_K10, FIPS_K0);
        n_checks++;
        if (kx.key_valid !== 1'b1 || kx.round_idx !== 4'd10 || kx.key_out !== FIPS_K10) begin
            n_fail++;
            $display("FAIL first_key: got valid=%b idx=%0d key=%h, want 1 10 %h",
                     kx.key_valid, kx.round_idx, kx.key_out, FIPS_K10);
        end
        for (cyc = 0; cyc < 40 && kx.done !== 1'b1; cyc++) tick();
        n_checks++;
        if (cyc != 11 || n_xfer - x0 != 11) begin
            n_fail++;
            $display("FAIL stream_len: got cycles=%0d transfers=%0d, want 11 11", cyc, n_xfer - x0);
        end
        n_checks++;
        if (kx.busy !== 1'b0 || kx.key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_state: got busy=%b valid=%b, want 0 0", kx.busy, kx.key_valid);
        end
        tick();
        n_checks++;
        if (kx.done !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_width: got done=%b pending=%0d, want 0 0", kx.done, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int stall = 0;
        int x0 = n_xfer;
        kx.out_ready = 1'b0;
        begin_run(FIPS_K10, FIPS_K0);
        for (cyc = 0; cyc < 400 && kx.done !== 1'b1; cyc++) begin
            if (kx.key_valid === 1'b1 && kx.round_idx === 4'd5 && stall < 8) begin
                kx.out_ready = 1'b0;
                stall++;
            end else begin
                kx.out_ready = 1'($urandom_range(0, 1));
            end
            tick();
        end
        n_checks++;
        if (kx.done !== 1'b1 || n_xfer - x0 != 11 || stall != 8 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL backpressure: got done=%b transfers=%0d stall=%0d pending=%0d, want 1 11 8 0",
                     kx.done, n_xfer - x0, stall, sb_q.size());
        end
        kx.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_start_busy();
        int cyc;
        int x0 = n_xfer;
        logic hit = 1'b0;
        kx.out_ready = 1'b1;
        begin_run(FIPS_K10, FIPS_K0);
        for (cyc = 0; cyc < 40 && kx.done !== 1'b1; cyc++) begin
            if (kx.round_idx === 4'd7 && !hit) begin
                kx.start  = 1'b1;
                kx.key_in = 128'h01234567_89abcdef_fedcba98_76543210;
                hit = 1'b1;
            end else begin
                kx.start = 1'b0;
            end
            tick();
        end
        kx.start = 1'b0;
        n_checks++;
        if (cyc != 11 || n_xfer - x0 != 11 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL start_busy: got cycles=%0d transfers=%0d pending=%0d, want 11 11 0",
                     cyc, n_xfer - x0, sb_q.size());
        end
        tick();
    endtask

    task automatic test_abort();
        int cyc;
        kx.out_ready = 1'b1;
        begin_run(FIPS_K10, FIPS_K0);
        for (cyc = 0; cyc < 20 && kx.round_idx !== 4'd4; cyc++) tick();
        kx.abort  = 1'b1;
        kx.start  = 1'b1;
        kx.key_in = ZERO_K10;
        tick();
        kx.abort = 1'b0;
        kx.start = 1'b0;
        sb_q.delete();
        n_checks++;
        if (kx.key_valid !== 1'b0 || kx.busy !== 1'b0 || kx.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got valid=%b busy=%b done=%b, want 0 0 0",
                     kx.key_valid, kx.busy, kx.done);
        end
        begin_run(FIPS_K10, FIPS_K0);
        n_checks++;
        if (kx.key_valid !== 1'b1 || kx.round_idx !== 4'd10 || kx.key_out !== FIPS_K10) begin
            n_fail++;
            $display("FAIL abort_restart: got valid=%b idx=%0d key=%h, want 1 10 %h",
                     kx.key_valid, kx.round_idx, kx.key_out, FIPS_K10);
        end
        for (cyc = 0; cyc < 40 && kx.done !== 1'b1; cyc++) tick();
        n_checks++;
        if (cyc != 11 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_rerun: got cycles=%0d pending=%0d, want 11 0", cyc, sb_q.size());
        end
        tick();
    endtask

    task automatic test_async_reset();
        int cyc;
        kx.out_ready = 1'b1;
        begin_run(FIPS_K10, FIPS_K0);
        for (cyc = 0; cyc < 20 && kx.round_idx !== 4'd6; cyc++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (kx.key_valid !== 1'b0 || kx.busy !== 1'b0 || kx.done !== 1'b0 ||
            kx.key_out !== 128'h0 || kx.round_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b busy=%b done=%b idx=%0d key=%h, want all 0",
                     kx.key_valid, kx.busy, kx.done, kx.round_idx, kx.key_out);
        end
        sb_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        kx.out_ready = 1'b1;
        begin_run(FIPS_K10, FIPS_K0);
        for (cyc = 0; cyc < 40 && kx.done !== 1'b1; cyc++) tick();
        push_stream(ZERO_K0);
        kx.start  = 1'b1;
        kx.key_in = ZERO_K10;
        tick();
        kx.start = 1'b0;
        n_checks++;
        if (kx.key_valid !== 1'b1 || kx.round_idx !== 4'd10 || kx.key_out !== ZERO_K10) begin
            n_fail++;
            $display("FAIL b2b_restart: got valid=%b idx=%0d key=%h, want 1 10 %h",
                     kx.key_valid, kx.round_idx, kx.key_out, ZERO_K10);
        end
        for (cyc = 0; cyc < 40 && kx.done !== 1'b1; cyc++) tick();
        n_checks++;
        if (cyc != 11 || kx.key_out !== ZERO_K0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_final: got cycles=%0d key=%h pending=%0d, want 11 %h 0",
                     cyc, kx.key_out, sb_q.size(), ZERO_K0);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fips_stream();
        test_backpressure();
        test_start_busy();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
